// File: rtl/blink_pkg.sv
// Shared constants for the blink RTC: I/O register map, status bit layout.
// The minute alarm is compiled in only when BLINK_RTC_ALARM_EN is defined.
package blink_pkg;

  typedef enum logic [7:0] {
    ADDR_TACK   = 8'hB4,
    ADDR_TMK    = 8'hB5,
    ADDR_ALM0   = 8'hB8,
    ADDR_ALM1   = 8'hB9,
    ADDR_ALM2   = 8'hBA,
    ADDR_TIM0   = 8'hD0,
    ADDR_SNAP1  = 8'hD1,
    ADDR_SNAPM0 = 8'hD2,
    ADDR_SNAPM1 = 8'hD3,
    ADDR_SNAPM2 = 8'hD4
  } blink_addr_e;

  localparam int unsigned ST_W    = 4;
  localparam int unsigned ST_TICK = 0;
  localparam int unsigned ST_SEC  = 1;
  localparam int unsigned ST_MIN  = 2;
  localparam int unsigned ST_ALM  = 3;

  // Byte idx of a 24-bit value, for multi-byte register readout.
  function automatic logic [7:0] byte_of(input logic [23:0] v, input int unsigned idx);
    return v[8*idx +: 8];
  endfunction

endpackage

// File: rtl/blink_strobe_edge.sv
// Rising-edge qualifier for a level I/O strobe: a strobe held for any
// number of cycles produces a single rise_o pulse in its first cycle.
module blink_strobe_edge (
  input  logic mck,
  input  logic rin,
  input  logic strobe_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge mck or posedge rin) begin
    if (rin) prev_q <= 1'b0;
    else     prev_q <= strobe_i;
  end

  assign rise_o = strobe_i & ~prev_q;

endmodule

// File: rtl/blink_rtc.sv
// Blink real-time clock: prescaled tick/second/minute counters, W1C status,
// interrupt mask and registered irq. Optional alarm via BLINK_RTC_ALARM_EN.
module blink_rtc
  import blink_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 49152,
  parameter int unsigned TICKS_PER_SEC = 200,
  parameter int unsigned SEC_PER_MIN   = 60,
  parameter int unsigned MIN_W         = 21
) (
  input  logic            mck,
  input  logic            rin,
  input  logic            restim,
  input  logic            io_rd,
  input  logic            io_wr,
  input  logic [7:0]      io_addr,
  input  logic [7:0]      io_wdata,
  output logic [7:0]      io_rdata,
  output logic [ST_W-1:0] tsta,
  output logic            irq
);

  localparam int unsigned TCK_W = $clog2(TICK_DIV);

  logic rd_rise, wr_rise;

  blink_strobe_edge u_rd_edge (
    .mck     (mck),
    .rin     (rin),
    .strobe_i(io_rd),
    .rise_o  (rd_rise)
  );

  blink_strobe_edge u_wr_edge (
    .mck     (mck),
    .rin     (rin),
    .strobe_i(io_wr),
    .rise_o  (wr_rise)
  );

  logic [TCK_W-1:0] tck_q, tck_d;
  logic [7:0]       tim0_q, tim0_d;
  logic [5:0]       tim1_q, tim1_d;
  logic [MIN_W-1:0] timm_q, timm_d;
  logic             tick_ev, sec_ev, min_ev, alm_ev;

  always_comb begin
    tck_d   = tck_q;
    tim0_d  = tim0_q;
    tim1_d  = tim1_q;
    timm_d  = timm_q;
    tick_ev = 1'b0;
    sec_ev  = 1'b0;
    min_ev  = 1'b0;
    if (restim) begin
      tck_d  = '0;
      tim0_d = '0;
      tim1_d = '0;
      timm_d = '0;
    end else if (tck_q == TCK_W'(TICK_DIV - 1)) begin
      tck_d   = '0;
      tick_ev = 1'b1;
      if (tim0_q == 8'(TICKS_PER_SEC - 1)) begin
        tim0_d = '0;
        sec_ev = 1'b1;
        if (tim1_q == 6'(SEC_PER_MIN - 1)) begin
          tim1_d = '0;
          min_ev = 1'b1;
          // Full-width increment wraps 2^MIN_W-1 to 0 as a normal minute.
          timm_d = timm_q + 1'b1;
        end else begin
          tim1_d = tim1_q + 1'b1;
        end
      end else begin
        tim0_d = tim0_q + 1'b1;
      end
    end else begin
      tck_d = tck_q + 1'b1;
    end
  end

`ifdef BLINK_RTC_ALARM_EN
  logic [MIN_W-1:0] alm_q, alm_d;
  logic [23:0]      alm_ext;

  always_comb begin
    alm_ext = 24'(alm_q);
    if (wr_rise) begin
      case (io_addr)
        ADDR_ALM0: alm_ext[7:0]   = io_wdata;
        ADDR_ALM1: alm_ext[15:8]  = io_wdata;
        ADDR_ALM2: alm_ext[23:16] = io_wdata;
        default: ;
      endcase
    end
    alm_d  = MIN_W'(alm_ext);
    alm_ev = min_ev && (timm_d == alm_q);
  end

  always_ff @(posedge mck or posedge rin) begin
    if (rin) alm_q <= '0;
    else     alm_q <= alm_d;
  end
`else
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^io_wdata[7:4];
  assign alm_ev          = 1'b0;
`endif

  logic [ST_W-1:0] tsta_q, tsta_d, set_v, clr_v;
  logic [ST_W-1:0] tmk_q, tmk_d;
  logic            irq_q, irq_d;

  always_comb begin
    set_v          = '0;
    set_v[ST_TICK] = tick_ev;
    set_v[ST_SEC]  = sec_ev;
    set_v[ST_MIN]  = min_ev;
    set_v[ST_ALM]  = alm_ev;
    clr_v          = (wr_rise && (io_addr == ADDR_TACK)) ? io_wdata[ST_W-1:0] : '0;
    // Clear first, then set: an event landing with a TACK keeps its bit.
    tsta_d         = (tsta_q & ~clr_v) | set_v;
`ifndef BLINK_RTC_ALARM_EN
    tsta_d[ST_ALM] = 1'b0;
`endif
    tmk_d = tmk_q;
    if (wr_rise && (io_addr == ADDR_TMK)) tmk_d = io_wdata[ST_W-1:0];
    irq_d = |(tsta_q & tmk_q);
  end

  logic [7:0]       rdata_q, rdata_d;
  logic [5:0]       snap1_q, snap1_d;
  logic [MIN_W-1:0] snapm_q, snapm_d;
  logic [23:0]      snapm_ext;

  always_comb begin
    rdata_d   = rdata_q;
    snap1_d   = snap1_q;
    snapm_d   = snapm_q;
    snapm_ext = 24'(snapm_q);
    if (rd_rise) begin
      case (io_addr)
        ADDR_TMK:    rdata_d = {4'b0, tsta_q};
        ADDR_TIM0: begin
          rdata_d = tim0_q;
          snap1_d = tim1_q;
          snapm_d = timm_q;
        end
        ADDR_SNAP1:  rdata_d = {2'b0, snap1_q};
        ADDR_SNAPM0: rdata_d = byte_of(snapm_ext, 0);
        ADDR_SNAPM1: rdata_d = byte_of(snapm_ext, 1);
        ADDR_SNAPM2: rdata_d = byte_of(snapm_ext, 2);
        default: ;
      endcase
    end
  end

  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      tck_q   <= '0;
      tim0_q  <= '0;
      tim1_q  <= '0;
      timm_q  <= '0;
      tsta_q  <= '0;
      tmk_q   <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
      snap1_q <= '0;
      snapm_q <= '0;
    end else begin
      tck_q   <= tck_d;
      tim0_q  <= tim0_d;
      tim1_q  <= tim1_d;
      timm_q  <= timm_d;
      tsta_q  <= tsta_d;
      tmk_q   <= tmk_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
      snap1_q <= snap1_d;
      snapm_q <= snapm_d;
    end
  end

  assign io_rdata = rdata_q;
  assign tsta     = tsta_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_blink_rtc.sv
// Self-checking bench for blink_rtc: directed table, corner sequences and a
// randomized run against a cycle-count based reference model.
module tb_blink_rtc;

  localparam int unsigned TD   = 4;
  localparam int unsigned TPS  = 5;
  localparam int unsigned SPM  = 3;
  localparam int unsigned MW   = 8;
  localparam int unsigned MPER = TD * TPS * SPM;

  logic       mck = 1'b0;
  logic       rin, restim, io_rd, io_wr;
  logic [7:0] io_addr, io_wdata, io_rdata;
  logic [3:0] tsta;
  logic       irq;

  always #5 mck = ~mck;

  blink_rtc #(
    .TICK_DIV     (TD),
    .TICKS_PER_SEC(TPS),
    .SEC_PER_MIN  (SPM),
    .MIN_W        (MW)
  ) dut (
    .mck     (mck),
    .rin     (rin),
    .restim  (restim),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .io_addr (io_addr),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .tsta    (tsta),
    .irq     (irq)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counters derived from the number of counted cycles.
  int unsigned m_n, m_snap1, m_snapm, m_alarm, nn, a, sh;
  logic [7:0]  m_rdata;
  logic [3:0]  m_tsta, m_tmk, setb, clrb;
  logic        m_irq, m_prev_rd, m_prev_wr, rd_e, wr_e;

  function automatic int unsigned tim0_of(input int unsigned n);
    return (n / TD) % TPS;
  endfunction
  function automatic int unsigned tim1_of(input int unsigned n);
    return (n / (TD * TPS)) % SPM;
  endfunction
  function automatic int unsigned timm_of(input int unsigned n);
    return (n / MPER) % (1 << MW);
  endfunction

  always @(posedge mck or posedge rin) begin
    if (rin) begin
      m_n = 0; m_snap1 = 0; m_snapm = 0; m_alarm = 0;
      m_rdata = 8'h00; m_tsta = 4'h0; m_tmk = 4'h0; m_irq = 1'b0;
      m_prev_rd = 1'b0; m_prev_wr = 1'b0;
    end else begin
      rd_e = io_rd && !m_prev_rd;
      wr_e = io_wr && !m_prev_wr;
      m_prev_rd = io_rd;
      m_prev_wr = io_wr;
      m_irq = |(m_tsta & m_tmk);
      setb = 4'h0;
      if (restim) nn = 0;
      else begin
        nn = m_n + 1;
        if ((nn % TD) == 0) setb[0] = 1'b1;
        if ((nn % (TD * TPS)) == 0) setb[1] = 1'b1;
        if ((nn % MPER) == 0) begin
          setb[2] = 1'b1;
`ifdef BLINK_RTC_ALARM_EN
          if (timm_of(nn) == m_alarm) setb[3] = 1'b1;
`endif
        end
      end
      clrb = (wr_e && io_addr == 8'hB4) ? io_wdata[3:0] : 4'h0;
      if (rd_e) begin
        case (io_addr)
          8'hB5: m_rdata = {4'h0, m_tsta};
          8'hD0: begin
            m_rdata = 8'(tim0_of(m_n));
            m_snap1 = tim1_of(m_n);
            m_snapm = timm_of(m_n);
          end
          8'hD1: m_rdata = 8'(m_snap1);
          8'hD2: m_rdata = 8'(m_snapm & 255);
          8'hD3: m_rdata = 8'((m_snapm >> 8) & 255);
          8'hD4: m_rdata = 8'((m_snapm >> 16) & 255);
          default: ;
        endcase
      end
      if (wr_e && io_addr == 8'hB5) m_tmk = io_wdata[3:0];
`ifdef BLINK_RTC_ALARM_EN
      if (wr_e && io_addr >= 8'hB8 && io_addr <= 8'hBA) begin
        sh = 8 * (int'(io_addr) - 8'hB8);
        a  = (m_alarm & ~(32'd255 << sh)) | (32'(io_wdata) << sh);
        m_alarm = a % (1 << MW);
      end
`endif
      m_tsta = (m_tsta & ~clrb) | setb;
      m_n = nn;
    end
  end

  logic chk_en = 1'b0;
  always @(negedge mck) begin
    if (chk_en && !rin) begin
      check("model_rdata", int'(io_rdata), int'(m_rdata));
      check("model_tsta", int'(tsta), int'(m_tsta));
      check("model_irq", int'(irq), int'(m_irq));
    end
  end

  typedef enum int { OP_NOP, OP_RD, OP_WR } op_e;
  typedef struct {
    int unsigned cyc;
    op_e         op;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [7:0]  e_rdata;
    logic [3:0]  e_tsta;
    logic        e_irq;
  } vec_t;

  vec_t tbl[15];
  int unsigned cyc_no;

  task automatic step();
    @(negedge mck);
    cyc_no++;
  endtask

  task automatic strobe(input op_e op, input logic [7:0] addr, input logic [7:0] data);
    io_addr  = addr;
    io_wdata = data;
    io_rd    = (op == OP_RD);
    io_wr    = (op == OP_WR);
    step();
    io_rd = 1'b0;
    io_wr = 1'b0;
  endtask

  logic [7:0] alist[12] = '{8'hB4, 8'hB5, 8'hD0, 8'hD1, 8'hD2, 8'hD3,
                            8'hD4, 8'hB8, 8'hB9, 8'hBA, 8'hB0, 8'h00};

  initial begin
    int unsigned k;
    logic        saw_zero, exp_zero;
    logic [3:0]  ts_before;

    tbl[0]  = '{2,  OP_RD,  8'hB5, 8'h00, 8'h00, 4'h0, 1'b0};
    tbl[1]  = '{5,  OP_RD,  8'hB5, 8'h00, 8'h01, 4'h1, 1'b0};
    tbl[2]  = '{7,  OP_WR,  8'hB4, 8'h01, 8'h01, 4'h0, 1'b0};
    tbl[3]  = '{9,  OP_RD,  8'hD0, 8'h00, 8'h02, 4'h1, 1'b0};
    tbl[4]  = '{12, OP_WR,  8'hB4, 8'h01, 8'h02, 4'h1, 1'b0};
    tbl[5]  = '{21, OP_RD,  8'hD0, 8'h00, 8'h00, 4'h3, 1'b0};
    tbl[6]  = '{23, OP_RD,  8'hD1, 8'h00, 8'h01, 4'h3, 1'b0};
    tbl[7]  = '{25, OP_WR,  8'hB4, 8'h0F, 8'h01, 4'h0, 1'b0};
    tbl[8]  = '{27, OP_RD,  8'hB0, 8'h00, 8'h01, 4'h0, 1'b0};
    tbl[9]  = '{29, OP_RD,  8'hB5, 8'h00, 8'h01, 4'h1, 1'b0};
    tbl[10] = '{31, OP_WR,  8'hB5, 8'h01, 8'h01, 4'h1, 1'b0};
    tbl[11] = '{33, OP_RD,  8'hB5, 8'h00, 8'h01, 4'h1, 1'b1};
    tbl[12] = '{35, OP_WR,  8'hB4, 8'h01, 8'h01, 4'h0, 1'b1};
    tbl[13] = '{36, OP_NOP, 8'h00, 8'h00, 8'h01, 4'h1, 1'b0};
    tbl[14] = '{38, OP_RD,  8'hD1, 8'h00, 8'h01, 4'h1, 1'b1};

    rin = 1'b1; restim = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
    io_addr = 8'h00; io_wdata = 8'h00; cyc_no = 0;
    repeat (3) @(negedge mck);
    check("reset_rdata", int'(io_rdata), 0);
    check("reset_tsta", int'(tsta), 0);
    check("reset_irq", int'(irq), 0);
    rin = 1'b0;
    chk_en = 1'b1;
    cyc_no = 0;

    foreach (tbl[i]) begin
      while (cyc_no + 1 < tbl[i].cyc) step();
      io_addr  = tbl[i].addr;
      io_wdata = tbl[i].data;
      io_rd    = (tbl[i].op == OP_RD);
      io_wr    = (tbl[i].op == OP_WR);
      step();
      check($sformatf("tbl%0d_rdata", i), int'(io_rdata), int'(tbl[i].e_rdata));
      check($sformatf("tbl%0d_tsta", i), int'(tsta), int'(tbl[i].e_tsta));
      check($sformatf("tbl%0d_irq", i), int'(irq), int'(tbl[i].e_irq));
      io_rd = 1'b0;
      io_wr = 1'b0;
    end

    // Held TACK strobe: acts once, a later tick re-sets the bit.
    for (k = 0; k < 20 && m_tsta[0] != 1'b1; k++) step();
    check("held_pre_tsta0", int'(tsta[0]), 1);
    exp_zero = (m_n % TD) != (TD - 1);
    saw_zero = 1'b0;
    io_addr = 8'hB4; io_wdata = 8'h01; io_wr = 1'b1;
    repeat (5) begin
      step();
      if (tsta[0] == 1'b0) saw_zero = 1'b1;
    end
    io_wr = 1'b0;
    check("held_saw_clear", int'(saw_zero), int'(exp_zero));
    check("held_final_tsta0", int'(tsta[0]), 1);

    // Coherent snapshot of the minutes counter.
    for (k = 0; k < 2000 && timm_of(m_n) != 8'h12; k++) step();
    check("snap_reached_timm", int'(timm_of(m_n)), 'h12);
    strobe(OP_RD, 8'hD0, 8'h00);
    repeat (MPER) step();
    strobe(OP_RD, 8'hD2, 8'h00);
    check("snap_d2", int'(io_rdata), 'h12);
    step();
    strobe(OP_RD, 8'hD4, 8'h00);
    check("snap_d4", int'(io_rdata), 'h00);
    step();

    // restim mid-second: status held, counters restart from 0.
    repeat (6) step();
    ts_before = m_tsta;
    restim = 1'b1;
    step();
    check("restim_tsta_kept", int'(tsta), int'(ts_before));
    strobe(OP_WR, 8'hB4, 8'h0F);
    step();
    restim = 1'b0;
    strobe(OP_RD, 8'hD0, 8'h00);
    check("restim_tim0_zero", int'(io_rdata), 0);
    check("restim_rel1_tsta", int'(tsta), 0);
    step();
    check("restim_rel2_tsta", int'(tsta), 0);
    step();
    check("restim_rel3_tsta", int'(tsta), 0);
    step();
    check("restim_first_tick", int'(tsta), 1);

    // Minute alarm at timm == 2.
    restim = 1'b1;
    strobe(OP_WR, 8'hB8, 8'h02);
    step();
    strobe(OP_WR, 8'hB5, 8'h08);
    step();
    strobe(OP_WR, 8'hB4, 8'h0F);
    restim = 1'b0;
    for (k = 0; k < 400 && timm_of(m_n) != 2; k++) step();
    check("alarm_reached_timm", int'(timm_of(m_n)), 2);
`ifdef BLINK_RTC_ALARM_EN
    check("alarm_tsta3", int'(tsta[3]), 1);
    step();
    check("alarm_irq", int'(irq), 1);
`else
    check("alarm_tsta3", int'(tsta[3]), 0);
    step();
    check("alarm_irq", int'(irq), 0);
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    repeat (3000) begin
      if ($urandom_range(0, 49) == 0) restim = ~restim;
      if (!io_rd && !io_wr) begin
        io_addr  = alist[$urandom_range(0, 11)];
        io_wdata = 8'($urandom);
      end
      io_rd = ($urandom_range(0, 5) == 0);
      io_wr = !io_rd && ($urandom_range(0, 6) == 0);
      step();
    end
    io_rd = 1'b0; io_wr = 1'b0; restim = 1'b0;
    step();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
